instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have ports: start  in  1  begin program load; base_addr  in  32  first write address.
REQ-003 SHALL have ports: in_valid  in  1; in_ready  out  1; in_op  in  6  operation index 0..36 (add=0 ... auipc=36, decoder out_signal bit order); in_rd/in_rs1/in_rs2  in  5 each; in_imm  in  32; in_last  in  1  final instruction.
REQ-004 SHALL have ports: mem_we  out  1; mem_addr  out  32; mem_wdata  out  32  encoded word; mem_ready  in  1  memory accepts write.
REQ-005 SHALL have ports: busy  out  1; done  out  1  one-cycle pulse; count  out  16  words written; err  out  1  sticky error.
REQ-006 Clocking/reset fixed: single clock clk; rst_n asynchronous assert, active low.

Function
REQ-007 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-008 IDLE: start=1 -> RUN next cycle; mem_addr<=base_addr, count<=0, err<=0.
REQ-009 Start while not IDLE SHALL be ignored.
REQ-010 in_ready SHALL be 1 only in RUN when the output register is empty or (mem_we && mem_ready) in the same cycle.
REQ-011 Transfer = in_valid && in_ready; encoded word SHALL appear on mem_wdata with mem_we=1 the next cycle (latency 1).
REQ-012 mem_we/mem_addr/mem_wdata SHALL hold stable until mem_ready=1.
REQ-013 On each completed write (mem_we && mem_ready): mem_addr += 4 (mod 2^32), count += 1 (wraps 0xFFFF->0).
REQ-014 Back-to-back: transfer and completed write in one cycle SHALL sustain one word/cycle.
REQ-015 Transfer with in_last=1 SHALL move RUN->DRAIN; DRAIN->DONE when output register empties; DONE->IDLE next cycle with done=1 for that one DONE cycle.
REQ-016 busy SHALL be 1 in RUN and DRAIN, else 0.
REQ-017 Encodings SHALL be canonical RV32I: R/I/S/B/U/J field placement, funct3/funct7 per ISA (sw funct3=2, jalr opcode 1100111, lui 0110111, srai funct7=0x20).
REQ-018 Immediate packing: I/S use in_imm[11:0]; shifts in_imm[4:0]; B in_imm[12:1]; J in_imm[20:1]; U in_imm[31:12]; unused bits ignored.
REQ-019 in_op > 36 SHALL emit 32'h00000013 (nop) and set err.
REQ-020 Unused register fields of a format SHALL be encoded as 0 where the format has no such field.

Reset
REQ-021 rst_n=0 SHALL force IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, count=0, err=0.
REQ-022 Reset mid-RUN/DRAIN SHALL discard any pending word; no write completes after assertion.

Configuration
REQ-023 Macro ENC_RANGE_CHECK_EN defined: err SHALL also set when in_imm does not sign-fit the format (I/S 12b, B 13b, J 21b), shift amount >31, or B/J offset odd; word still written truncated.
REQ-024 Macro undefined: no range checks; only REQ-019 sets err.

Structure
REQ-025 Shared package instr_pkg SHALL hold opcode constants, funct3/funct7 constants, the 37-entry op index enumeration, and the NOP constant; shared with decoder.
REQ-026 Combinational field packing SHALL live in sub-module instr_enc_core (op+fields -> 32-bit word, range-error flag); instr_encoder holds FSM, output register, counters.

Verification
REQ-027 start, base_addr=0x100, op=addi(10) rd=1 rs1=0 imm=5 last=1 -> mem_wdata=0x00500093 at 0x100, done pulse, count=1.
REQ-028 op=sw(26) rs1=2 rs2=3 imm=8 -> 0x00312423; op=beq(27) rs1=1 rs2=2 imm=-4 -> 0xFE208EE3.
REQ-029 Three words, mem_ready low 2 cycles on second -> word held stable, addresses 0x100/0x104/0x108, count=3.
REQ-030 in_op=40 -> 0x00000013 written, err=1 until next start.
REQ-031 With ENC_RANGE_CHECK_EN, addi imm=2048 -> err=1, word 0x80000093; without macro err=0.
REQ-032 rst_n low while mem_we=1 -> all outputs reset values same cycle, no done pulse.

Source files
------------

// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - RV32I encoding constants and op index enumeration shared by encoder and decoder.
package instr_pkg;

  typedef enum logic [5:0] {
    OP_ADD   = 6'd0,  OP_SUB   = 6'd1,  OP_SLL   = 6'd2,  OP_SLT   = 6'd3,
    OP_SLTU  = 6'd4,  OP_XOR   = 6'd5,  OP_SRL   = 6'd6,  OP_SRA   = 6'd7,
    OP_OR    = 6'd8,  OP_AND   = 6'd9,  OP_ADDI  = 6'd10, OP_SLTI  = 6'd11,
    OP_SLTIU = 6'd12, OP_XORI  = 6'd13, OP_ORI   = 6'd14, OP_ANDI  = 6'd15,
    OP_SLLI  = 6'd16, OP_SRLI  = 6'd17, OP_SRAI  = 6'd18, OP_LB    = 6'd19,
    OP_LH    = 6'd20, OP_LW    = 6'd21, OP_LBU   = 6'd22, OP_LHU   = 6'd23,
    OP_SB    = 6'd24, OP_SH    = 6'd25, OP_SW    = 6'd26, OP_BEQ   = 6'd27,
    OP_BNE   = 6'd28, OP_BLT   = 6'd29, OP_BGE   = 6'd30, OP_BLTU  = 6'd31,
    OP_BGEU  = 6'd32, OP_JAL   = 6'd33, OP_JALR  = 6'd34, OP_LUI   = 6'd35,
    OP_AUIPC = 6'd36
  } op_e;

  localparam int NUM_OPS = 37;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR = 3'd4, F3_SR  = 3'd5, F3_OR  = 3'd6, F3_AND  = 3'd7;
  localparam logic [2:0] F3_B   = 3'd0, F3_H   = 3'd1, F3_W   = 3'd2, F3_BU   = 3'd4, F3_HU = 3'd5;
  localparam logic [2:0] F3_BEQ = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4, F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6, F3_BGEU = 3'd7;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/instr_enc_core.sv
// rtl/instr_enc_core.sv - combinational RV32I field packing; range checks under ENC_RANGE_CHECK_EN.
module instr_enc_core
  import instr_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        op_err,
  output logic        range_err
);

  fmt_e       fmt;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  always_comb begin
    fmt    = FMT_R;
    opcode = OPC_OP;
    funct3 = F3_ADD;
    funct7 = F7_BASE;
    op_err = 1'b0;
    case (op)
      OP_ADD:   funct3 = F3_ADD;
      OP_SUB:   funct7 = F7_ALT;
      OP_SLL:   funct3 = F3_SLL;
      OP_SLT:   funct3 = F3_SLT;
      OP_SLTU:  funct3 = F3_SLTU;
      OP_XOR:   funct3 = F3_XOR;
      OP_SRL:   funct3 = F3_SR;
      OP_SRA:   begin funct3 = F3_SR; funct7 = F7_ALT; end
      OP_OR:    funct3 = F3_OR;
      OP_AND:   funct3 = F3_AND;
      OP_ADDI:  begin fmt = FMT_I; opcode = OPC_OPIMM; funct3 = F3_ADD;  end
      OP_SLTI:  begin fmt = FMT_I; opcode = OPC_OPIMM; funct3 = F3_SLT;  end
      OP_SLTIU: begin fmt = FMT_I; opcode = OPC_OPIMM; funct3 = F3_SLTU; end
      OP_XORI:  begin fmt = FMT_I; opcode = OPC_OPIMM; funct3 = F3_XOR;  end
      OP_ORI:   begin fmt = FMT_I; opcode = OPC_OPIMM; funct3 = F3_OR;   end
      OP_ANDI:  begin fmt = FMT_I; opcode = OPC_OPIMM; funct3 = F3_AND;  end
      OP_SLLI:  begin fmt = FMT_SH; opcode = OPC_OPIMM; funct3 = F3_SLL; end
      OP_SRLI:  begin fmt = FMT_SH; opcode = OPC_OPIMM; funct3 = F3_SR;  end
      OP_SRAI:  begin fmt = FMT_SH; opcode = OPC_OPIMM; funct3 = F3_SR; funct7 = F7_ALT; end
      OP_LB:    begin fmt = FMT_I; opcode = OPC_LOAD; funct3 = F3_B;  end
      OP_LH:    begin fmt = FMT_I; opcode = OPC_LOAD; funct3 = F3_H;  end
      OP_LW:    begin fmt = FMT_I; opcode = OPC_LOAD; funct3 = F3_W;  end
      OP_LBU:   begin fmt = FMT_I; opcode = OPC_LOAD; funct3 = F3_BU; end
      OP_LHU:   begin fmt = FMT_I; opcode = OPC_LOAD; funct3 = F3_HU; end
      OP_SB:    begin fmt = FMT_S; opcode = OPC_STORE; funct3 = F3_B; end
      OP_SH:    begin fmt = FMT_S; opcode = OPC_STORE; funct3 = F3_H; end
      OP_SW:    begin fmt = FMT_S; opcode = OPC_STORE; funct3 = F3_W; end
      OP_BEQ:   begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = F3_BEQ;  end
      OP_BNE:   begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = F3_BNE;  end
      OP_BLT:   begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = F3_BLT;  end
      OP_BGE:   begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = F3_BGE;  end
      OP_BLTU:  begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = F3_BLTU; end
      OP_BGEU:  begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = F3_BGEU; end
      OP_JAL:   begin fmt = FMT_J; opcode = OPC_JAL;   end
      OP_JALR:  begin fmt = FMT_I; opcode = OPC_JALR;  end
      OP_LUI:   begin fmt = FMT_U; opcode = OPC_LUI;   end
      OP_AUIPC: begin fmt = FMT_U; opcode = OPC_AUIPC; end
      default:  op_err = 1'b1;
    endcase
  end

  // Register fields a format lacks are simply not placed, so they encode as zero.
  always_comb begin
    word = NOP;
    if (!op_err) begin
      case (fmt)
        FMT_R:  word = {funct7, rs2, rs1, funct3, rd, opcode};
        FMT_I:  word = {imm[11:0], rs1, funct3, rd, opcode};
        FMT_SH: word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        FMT_S:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        FMT_B:  word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        FMT_U:  word = {imm[31:12], rd, opcode};
        FMT_J:  word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        default: word = NOP;
      endcase
    end
  end

`ifdef ENC_RANGE_CHECK_EN
  logic fit12, fit13, fit21, shamt_ok;

  assign fit12    = (imm[31:11] == {21{imm[11]}});
  assign fit13    = (imm[31:12] == {20{imm[12]}});
  assign fit21    = (imm[31:20] == {12{imm[20]}});
  assign shamt_ok = (imm[31:5] == 27'd0);

  always_comb begin
    range_err = 1'b0;
    if (!op_err) begin
      case (fmt)
        FMT_I, FMT_S: range_err = !fit12;
        FMT_SH:       range_err = !shamt_ok;
        FMT_B:        range_err = !fit13 || imm[0];
        FMT_J:        range_err = !fit21 || imm[0];
        default:      range_err = 1'b0;
      endcase
    end
  end
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - program loader: encodes instructions and writes them to memory.
// Optional immediate range checking is enabled by defining ENC_RANGE_CHECK_EN.
module instr_encoder
  import instr_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  input  logic        in_last,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] count,
  output logic        err
);

  state_e      state, state_next;
  logic [31:0] enc_word;
  logic        op_err, range_err;
  logic        xfer, wr_done;

  instr_enc_core u_core (
    .op        (in_op),
    .rd        (in_rd),
    .rs1       (in_rs1),
    .rs2       (in_rs2),
    .imm       (in_imm),
    .word      (enc_word),
    .op_err    (op_err),
    .range_err (range_err)
  );

  // The output register accepts a new word when empty or when it drains this cycle.
  assign wr_done  = mem_we && mem_ready;
  assign in_ready = (state == RUN) && (!mem_we || mem_ready);
  assign xfer     = in_valid && in_ready;
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (xfer && in_last) state_next = DRAIN;
      DRAIN:   if (!mem_we || mem_ready) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      count     <= 16'd0;
      err       <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        mem_addr <= base_addr;
        count    <= 16'd0;
        err      <= 1'b0;
      end
      if (wr_done) begin
        mem_addr <= mem_addr + 32'd4;
        count    <= count + 16'd1;
      end
      if (xfer) begin
        mem_we    <= 1'b1;
        mem_wdata <= enc_word;
        if (op_err || range_err) err <= 1'b1;
      end else if (wr_done) begin
        mem_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized self-checking bench for instr_encoder against an ISA-level model.
module tb_instr_encoder;

  logic        clk, rst_n, start, in_valid, in_ready, in_last;
  logic        mem_we, mem_ready, busy, done, err;
  logic [31:0] base_addr, in_imm, mem_addr, mem_wdata;
  logic [5:0]  in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [15:0] count;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
  } ins_t;

  ins_t        prog[$];
  logic [31:0] got_w[$];
  int          checks = 0;
  int          passed = 0;

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .busy(busy), .done(done), .count(count), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ins_t mk(input int op, input int rd, input int rs1, input int rs2,
                              input logic [31:0] imm);
    ins_t r;
    r.op = op[5:0]; r.rd = rd[4:0]; r.rs1 = rs1[4:0]; r.rs2 = rs2[4:0]; r.imm = imm;
    return r;
  endfunction

  // fmt codes: 0 R, 1 I, 2 shift, 3 S, 4 B, 5 U, 6 J
  function automatic logic [31:0] model_word(input ins_t i);
    int op, f3, f7, opc, fmt;
    int r_f3[10], a_f3[6], l_f3[5], b_f3[6];
    logic [31:0] m, w, rd, s1, s2, hi7;
    r_f3 = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    a_f3 = '{0, 2, 3, 4, 6, 7};
    l_f3 = '{0, 1, 2, 4, 5};
    b_f3 = '{0, 1, 4, 5, 6, 7};
    op = int'(i.op); m = i.imm; f3 = 0; f7 = 0; opc = 0; fmt = 0;
    if (op > 36) return 32'h0000_0013;
    if (op <= 9)       begin fmt = 0; opc = 'h33; f3 = r_f3[op]; f7 = (op == 1 || op == 7) ? 32 : 0; end
    else if (op <= 15) begin fmt = 1; opc = 'h13; f3 = a_f3[op-10]; end
    else if (op <= 18) begin fmt = 2; opc = 'h13; f3 = (op == 16) ? 1 : 5; f7 = (op == 18) ? 32 : 0; end
    else if (op <= 23) begin fmt = 1; opc = 'h03; f3 = l_f3[op-19]; end
    else if (op <= 26) begin fmt = 3; opc = 'h23; f3 = op - 24; end
    else if (op <= 32) begin fmt = 4; opc = 'h63; f3 = b_f3[op-27]; end
    else if (op == 33) begin fmt = 6; opc = 'h6F; end
    else if (op == 34) begin fmt = 1; opc = 'h67; end
    else if (op == 35) begin fmt = 5; opc = 'h37; end
    else               begin fmt = 5; opc = 'h17; end
    rd  = 32'(i.rd) << 7;
    s1  = 32'(i.rs1) << 15;
    s2  = 32'(i.rs2) << 20;
    hi7 = 32'(f7) << 25;
    w = 32'(opc) | (32'(f3) << 12);
    case (fmt)
      0: w = w | rd | s1 | s2 | hi7;
      1: w = w | rd | s1 | ((m & 32'hFFF) << 20);
      2: w = w | rd | s1 | ((m & 32'd31) << 20) | hi7;
      3: w = w | s1 | s2 | ((m & 32'd31) << 7) | (((m >> 5) & 32'd127) << 25);
      4: w = w | s1 | s2 | (((m >> 12) & 32'd1) << 31) | (((m >> 5) & 32'd63) << 25)
               | (((m >> 1) & 32'd15) << 8) | (((m >> 11) & 32'd1) << 7);
      5: w = w | rd | (m & 32'hFFFF_F000);
      default: w = w | rd | (((m >> 20) & 32'd1) << 31) | (((m >> 1) & 32'd1023) << 21)
                     | (((m >> 11) & 32'd1) << 20) | (m & 32'h000F_F000);
    endcase
    return w;
  endfunction

  function automatic bit model_err(input ins_t i);
    int op;
    op = int'(i.op);
    if (op > 36) return 1'b1;
`ifdef ENC_RANGE_CHECK_EN
    begin
      int s;
      s = int'($signed(i.imm));
      if ((op >= 10 && op <= 15) || (op >= 19 && op <= 26) || op == 34)
        return (s < -2048 || s > 2047);
      if (op >= 16 && op <= 18) return (i.imm > 32'd31);
      if (op >= 27 && op <= 32) return (s < -4096 || s > 4095 || i.imm[0]);
      if (op == 33) return (s < -(1 << 20) || s > (1 << 20) - 1 || i.imm[0]);
    end
`endif
    return 1'b0;
  endfunction

  function automatic ins_t rand_ins();
    logic [31:0] imm;
    int op;
    op = ($urandom_range(0, 99) < 6) ? $urandom_range(37, 63) : $urandom_range(0, 36);
    case ($urandom_range(0, 3))
      0:       imm = 32'($urandom_range(0, 63)) - 32'd32;
      1:       imm = $urandom;
      2:       imm = ($urandom_range(0, 1) != 0) ? 32'd2047 : 32'hFFFF_F800;
      default: imm = 32'($urandom_range(0, 40));
    endcase
    return mk(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), imm);
  endfunction

  task automatic run_program(input logic [31:0] base, input int mode, input int gap_pct,
                             input bit noise);
    int n, idx, wr, ndone, cyc, stall;
    bit held, exp_err;
    logic [31:0] h_addr, h_data, exp_w, exp_a;
    n = prog.size(); idx = 0; wr = 0; ndone = 0; cyc = 0; stall = 0; held = 0; exp_err = 0;
    h_addr = 0; h_data = 0;
    got_w.delete();
    foreach (prog[k]) exp_err |= model_err(prog[k]);
    start = 1'b1; base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) $display("FAIL start_busy: got %b want 1", busy); else passed++;
    checks++; if (mem_addr !== base) $display("FAIL start_addr: got %h want %h", mem_addr, base); else passed++;
    checks++; if (count !== 16'd0 || err !== 1'b0)
      $display("FAIL start_clear: count %0d err %b want 0 0", count, err); else passed++;
    while (ndone == 0 && cyc < 3000) begin
      cyc++;
      if (idx < n && $urandom_range(0, 99) >= gap_pct) begin
        in_valid = 1'b1; in_op = prog[idx].op; in_rd = prog[idx].rd; in_rs1 = prog[idx].rs1;
        in_rs2 = prog[idx].rs2; in_imm = prog[idx].imm; in_last = (idx == n - 1);
      end else begin
        in_valid = 1'b0; in_op = 6'($urandom); in_last = 1'($urandom);
      end
      case (mode)
        0: mem_ready = 1'b1;
        1: mem_ready = ($urandom_range(0, 99) < 70);
        default: begin
          if (mem_we && wr == 1 && stall < 2) begin mem_ready = 1'b0; stall++; end
          else mem_ready = 1'b1;
        end
      endcase
      if (noise) begin start = 1'($urandom); base_addr = $urandom; end
      @(negedge clk);
      if (done) begin
        ndone++;
        checks++; if (count !== 16'(n)) $display("FAIL done_count: got %0d want %0d", count, n); else passed++;
      end
      if (mem_we) begin
        if (held) begin
          checks++;
          if (mem_addr !== h_addr || mem_wdata !== h_data)
            $display("FAIL hold_stable: got %h/%h want %h/%h", mem_addr, mem_wdata, h_addr, h_data);
          else passed++;
        end
        if (mem_ready) begin
          exp_w = (wr < n) ? model_word(prog[wr]) : 32'hxxxx_xxxx;
          exp_a = base + 32'(4 * wr);
          checks++; if (mem_wdata !== exp_w)
            $display("FAIL wdata[%0d]: got %h want %h", wr, mem_wdata, exp_w); else passed++;
          checks++; if (mem_addr !== exp_a)
            $display("FAIL waddr[%0d]: got %h want %h", wr, mem_addr, exp_a); else passed++;
          got_w.push_back(mem_wdata);
          wr++; held = 0;
        end else begin
          held = 1; h_addr = mem_addr; h_data = mem_wdata;
        end
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; start = 1'b0; mem_ready = 1'b1;
    checks++; if (ndone != 1) $display("FAIL done_seen: got %0d pulses want 1 (cycles %0d)", ndone, cyc); else passed++;
    checks++; if (wr != n) $display("FAIL writes: got %0d want %0d", wr, n); else passed++;
    checks++; if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL after_done: done %b busy %b want 0 0", done, busy); else passed++;
    checks++; if (count !== 16'(n)) $display("FAIL idle_count: got %0d want %0d", count, n); else passed++;
    checks++; if (err !== exp_err) $display("FAIL err: got %b want %b", err, exp_err); else passed++;
  endtask

  task automatic test_reset();
    checks++; if (mem_we !== 0 || mem_addr !== 0 || mem_wdata !== 0)
      $display("FAIL reset_mem: we %b addr %h data %h want 0", mem_we, mem_addr, mem_wdata); else passed++;
    checks++; if (busy !== 0 || done !== 0 || count !== 0 || err !== 0 || in_ready !== 0)
      $display("FAIL reset_status: busy %b done %b count %0d err %b rdy %b want 0",
               busy, done, count, err, in_ready); else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 0 || in_ready !== 0)
      $display("FAIL idle_after_reset: busy %b rdy %b want 0 0", busy, in_ready); else passed++;
  endtask

  task automatic test_single_addi();
    logic [31:0] w0;
    prog.delete();
    prog.push_back(mk(10, 1, 0, 0, 32'd5));
    run_program(32'h100, 0, 0, 0);
    w0 = (got_w.size() > 0) ? got_w[0] : 32'hxxxx_xxxx;
    checks++; if (w0 !== 32'h0050_0093) $display("FAIL addi_word: got %h want 00500093", w0); else passed++;
  endtask

  task automatic test_store_branch();
    logic [31:0] w0, w1;
    prog.delete();
    prog.push_back(mk(26, 0, 2, 3, 32'd8));
    prog.push_back(mk(27, 0, 1, 2, 32'hFFFF_FFFC));
    run_program(32'h100, 1, 30, 1);
    w0 = (got_w.size() > 0) ? got_w[0] : 32'hxxxx_xxxx;
    w1 = (got_w.size() > 1) ? got_w[1] : 32'hxxxx_xxxx;
    checks++; if (w0 !== 32'h0031_2423) $display("FAIL sw_word: got %h want 00312423", w0); else passed++;
    checks++; if (w1 !== 32'hFE20_8EE3) $display("FAIL beq_word: got %h want fe208ee3", w1); else passed++;
  endtask

  task automatic test_stall();
    prog.delete();
    prog.push_back(mk(0, 3, 1, 2, 32'd0));
    prog.push_back(mk(18, 4, 5, 0, 32'd7));
    prog.push_back(mk(35, 6, 0, 0, 32'h1234_5000));
    run_program(32'h100, 2, 0, 0);
  endtask

  task automatic test_bad_op();
    logic [31:0] w1;
    prog.delete();
    prog.push_back(mk(10, 1, 1, 0, 32'd1));
    prog.push_back(mk(40, 7, 7, 7, 32'hFFFF_FFFF));
    prog.push_back(mk(10, 2, 2, 0, 32'd2));
    run_program(32'h40, 0, 0, 0);
    w1 = (got_w.size() > 1) ? got_w[1] : 32'hxxxx_xxxx;
    checks++; if (w1 !== 32'h0000_0013) $display("FAIL bad_op_word: got %h want 00000013", w1); else passed++;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err); else passed++;
  endtask

  task automatic test_range();
    logic [31:0] w0;
    prog.delete();
    prog.push_back(mk(10, 1, 0, 0, 32'd2048));
    run_program(32'h300, 0, 0, 0);
    w0 = (got_w.size() > 0) ? got_w[0] : 32'hxxxx_xxxx;
    checks++; if (w0 !== 32'h8000_0093) $display("FAIL range_word: got %h want 80000093", w0); else passed++;
  endtask

  task automatic test_random();
    for (int p = 0; p < 8; p++) begin
      prog.delete();
      for (int k = 0; k < $urandom_range(1, 16); k++) prog.push_back(rand_ins());
      run_program((p == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC), 1, 30, 1);
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; base_addr = 32'h200;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1; in_op = 6'd10; in_rd = 5'd2; in_rs1 = 5'd1; in_rs2 = 5'd0;
    in_imm = 32'd7; in_last = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (mem_we !== 1'b1) $display("FAIL pre_reset_we: got %b want 1", mem_we); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_we !== 0 || mem_addr !== 0 || mem_wdata !== 0)
      $display("FAIL midreset_mem: we %b addr %h data %h want 0", mem_we, mem_addr, mem_wdata); else passed++;
    checks++; if (busy !== 0 || done !== 0 || count !== 0 || err !== 0 || in_ready !== 0)
      $display("FAIL midreset_status: busy %b done %b count %0d err %b rdy %b want 0",
               busy, done, count, err, in_ready); else passed++;
    mem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++; if (mem_we !== 0 || done !== 0)
        $display("FAIL in_reset_quiet: we %b done %b want 0 0", mem_we, done); else passed++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++; if (done !== 0 || busy !== 0 || mem_we !== 0)
        $display("FAIL post_reset_idle: done %b busy %b we %b want 0", done, busy, mem_we); else passed++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = 32'd0; in_valid = 1'b0; in_op = 6'd0;
    in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0; in_last = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_addi();
    test_store_branch();
    test_stall();
    test_bad_op();
    test_range();
    test_random();
    @(posedge clk); #1;
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
